// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline: lane-aligned data-memory handshake and MEM/WB register.
// Optional MEM_MISALIGN_CHECK_EN flags and suppresses misaligned half/word accesses instead of masking.
module memory_access #(
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic [4:0]         i_write_reg,
  input  logic               i_mem2Reg,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [NB_DATA-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  output logic [3:0]         o_mem_be,
  input  logic               i_mem_ack,
  input  logic [NB_DATA-1:0] i_mem_rdata,
  output logic               o_stall,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [4:0]         o_write_reg,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic               o_misaligned
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;

  state_e state_q, state_d;

  logic               we_q;
  logic [NB_DATA-1:0] addr_q, wdata_q;
  logic [3:0]         be_q;
  logic               ld_q, sign_q;
  logic [1:0]         k_q, width_q;

  logic [NB_DATA-1:0] read_data_q, alu_result_q;
  logic [4:0]         write_reg_q;
  logic               mem2reg_q, regwrite_q;

  logic               access, misalign, start, wb_load;
  logic [1:0]         lane_k, k_eff;
  logic [3:0]         be_d;
  logic [NB_DATA-1:0] wdata_d;

  assign access = i_memRead | i_memWrite;
  assign lane_k = i_result[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = access & (state_q == ST_IDLE) &
                    (((i_width == W_HALF) & lane_k[0]) | (i_width[1] & (lane_k != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Lane offset with the low bits masked to the access size; byte accesses keep the full offset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    k_eff   = 2'b00;
    be_d    = 4'b1111;
    wdata_d = i_data4Mem;
    case (i_width)
      W_BYTE: begin
        k_eff   = lane_k;
        be_d    = 4'b0001 << lane_k;
        wdata_d = {4{i_data4Mem[7:0]}};
      end
      W_HALF: begin
        k_eff   = {lane_k[1], 1'b0};
        be_d    = lane_k[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{i_data4Mem[15:0]}};
      end
      default: ;
    endcase
    if (!i_memWrite) be_d = 4'b1111;
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] k,
                                          input logic [1:0] width, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = k[1] ? w[31:16] : w[15:0];
    case (width)
      W_BYTE:  return {{24{sgn & b[7]}}, b};
      W_HALF:  return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wb_load = 1'b0;
    o_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!i_halt) begin
          if (access && !misalign) begin
            start   = 1'b1;
            o_stall = 1'b1;
            state_d = ST_WAIT;
          end else begin
            wb_load = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Halt is deliberately not looked at here: an in-flight access always completes.
        o_stall = !i_mem_ack;
        if (i_mem_ack) begin
          wb_load = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ld_q    <= 1'b0;
      sign_q  <= 1'b0;
      k_q     <= '0;
      width_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state_q <= state_d;
      if (start) begin
        we_q    <= i_memWrite;
        addr_q  <= {i_result[NB_DATA-1:2], 2'b00};
        wdata_q <= wdata_d;
        be_q    <= be_d;
        ld_q    <= i_memRead;
        sign_q  <= i_sign_flag;
        k_q     <= k_eff;
        width_q <= i_width;
      end else if (state_q == ST_WAIT && i_mem_ack) begin
        we_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      mem2reg_q    <= 1'b0;
      regwrite_q   <= 1'b0;
    end else if (wb_load) begin
      alu_result_q <= i_result;
      write_reg_q  <= i_write_reg;
      mem2reg_q    <= i_mem2Reg;
      regwrite_q   <= i_regWrite & !misalign;
      read_data_q  <= (state_q == ST_WAIT && ld_q) ? extract(i_mem_rdata, k_q, width_q, sign_q) : '0;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned_q;
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)     misaligned_q <= 1'b0;
    else if (wb_load) misaligned_q <= misalign;
  end
  assign o_misaligned = misaligned_q;
`else
  assign o_misaligned = 1'b0;
`endif

  assign o_mem_req    = (state_q == ST_WAIT);
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_be     = be_q;
  assign o_read_data  = read_data_q;
  assign o_alu_result = alu_result_q;
  assign o_write_reg  = write_reg_q;
  assign o_mem2reg    = mem2reg_q;
  assign o_regWrite   = regwrite_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access: loads, stores, lanes, halt, misalignment, reset in WAIT.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_halt;
  logic [31:0] i_result, i_data4Mem;
  logic [4:0]  i_write_reg;
  logic        i_mem2Reg, i_memRead, i_memWrite, i_regWrite;
  logic [1:0]  i_width;
  logic        i_sign_flag;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_stall;
  logic [31:0] o_read_data, o_alu_result;
  logic [4:0]  o_write_reg;
  logic        o_mem2reg, o_regWrite, o_misaligned;

  int errors = 0;
  int checks = 0;

  memory_access #(.NB_DATA(32)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_halt(i_halt),
    .i_result(i_result), .i_data4Mem(i_data4Mem), .i_write_reg(i_write_reg),
    .i_mem2Reg(i_mem2Reg), .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
    .i_width(i_width), .i_sign_flag(i_sign_flag),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_stall(o_stall), .o_read_data(o_read_data), .o_alu_result(o_alu_result),
    .o_write_reg(o_write_reg), .o_mem2reg(o_mem2reg), .o_regWrite(o_regWrite),
    .o_misaligned(o_misaligned)
  );

  always #5 clk = ~clk;

  task automatic set_nop();
    i_halt = 1'b0; i_result = '0; i_data4Mem = '0; i_write_reg = '0;
    i_mem2Reg = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0; i_regWrite = 1'b0;
    i_width = 2'b11; i_sign_flag = 1'b0;
  endtask

  task automatic set_op(input logic [31:0] res, input logic [31:0] data, input logic [4:0] wreg,
                        input logic m2r, input logic rd, input logic wr, input logic rw,
                        input logic [1:0] width, input logic sgn);
    i_result = res; i_data4Mem = data; i_write_reg = wreg; i_mem2Reg = m2r;
    i_memRead = rd; i_memWrite = wr; i_regWrite = rw; i_width = width; i_sign_flag = sgn;
  endtask

  // Called at posedge+1 with the access already on the inputs; returns at posedge+1 after the ack edge.
  task automatic run_access(input int waits, input logic [31:0] rdata, input logic halt_mid,
                            output int stall_cnt, output logic req_ok,
                            output logic [31:0] addr1, output logic [31:0] wdata1,
                            output logic [3:0] be1, output logic we1);
    stall_cnt = 0; req_ok = 1'b1;
    addr1 = '0; wdata1 = '0; be1 = '0; we1 = 1'b0;
    @(negedge clk);
    if (o_stall) stall_cnt++;
    if (o_mem_req) req_ok = 1'b0;
    @(posedge clk); #1;
    i_halt = halt_mid;
    for (int c = 1; c <= waits + 1; c++) begin
      if (c == waits + 1) begin i_mem_ack = 1'b1; i_mem_rdata = rdata; end
      @(negedge clk);
      if (o_stall) stall_cnt++;
      if (!o_mem_req) req_ok = 1'b0;
      if (c == 1) begin addr1 = o_mem_addr; wdata1 = o_mem_wdata; be1 = o_mem_be; we1 = o_mem_we; end
      @(posedge clk); #1;
    end
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    set_nop();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    set_nop();
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", o_mem_req); end
    checks++; if ({o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata} !== '0) begin errors++;
      $display("FAIL reset_mem_port: we=%b be=%h addr=%h wdata=%h want all 0", o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata); end
    checks++; if ({o_read_data, o_alu_result, o_write_reg, o_mem2reg, o_regWrite, o_misaligned} !== '0) begin errors++;
      $display("FAIL reset_memwb: rd=%h alu=%h wr=%h want all 0", o_read_data, o_alu_result, o_write_reg); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", o_stall); end
    i_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    int sc; logic ok; logic [31:0] a, wd; logic [3:0] be; logic we;
    set_op(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    run_access(3, 32'hDEADBEEF, 1'b0, sc, ok, a, wd, be, we);
    checks++; if (sc !== 4) begin errors++; $display("FAIL wload_stall_cycles: got %0d want 4", sc); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wload_req_window: got %b want 1", ok); end
    checks++; if ({a, be, we} !== {32'h10, 4'hF, 1'b0}) begin errors++;
      $display("FAIL wload_port: addr=%h be=%h we=%b want 00000010 f 0", a, be, we); end
    checks++; if (o_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wload_data: got %h want deadbeef", o_read_data); end
    checks++; if ({o_regWrite, o_mem2reg, o_write_reg, o_alu_result} !== {1'b1, 1'b1, 5'd5, 32'h10}) begin errors++;
      $display("FAIL wload_ctrl: rw=%b m2r=%b wr=%0d alu=%h want 1 1 5 10", o_regWrite, o_mem2reg, o_write_reg, o_alu_result); end
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL wload_req_clear: got %b want 0", o_mem_req); end
  endtask

  task automatic test_byte_load();
    int sc; logic ok; logic [31:0] a, wd; logic [3:0] be; logic we;
    set_op(32'h13, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
    run_access(0, 32'h80FF_0000, 1'b0, sc, ok, a, wd, be, we);
    checks++; if (sc !== 1) begin errors++; $display("FAIL bload_min_latency: stall cycles %0d want 1", sc); end
    checks++; if (a !== 32'h10) begin errors++; $display("FAIL bload_addr: got %h want 00000010", a); end
    checks++; if (o_read_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL bload_signed: got %h want ffffff80", o_read_data); end
    set_op(32'h13, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    run_access(1, 32'h80FF_0000, 1'b0, sc, ok, a, wd, be, we);
    checks++; if (o_read_data !== 32'h0000_0080) begin errors++; $display("FAIL bload_unsigned: got %h want 00000080", o_read_data); end
  endtask

  task automatic test_half_store();
    int sc; logic ok; logic [31:0] a, wd; logic [3:0] be; logic we;
    set_op(32'h22, 32'h1234ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    run_access(1, 32'h0, 1'b0, sc, ok, a, wd, be, we);
    checks++; if (be !== 4'b1100) begin errors++; $display("FAIL hstore_be: got %b want 1100", be); end
    checks++; if (wd !== 32'hABCDABCD) begin errors++; $display("FAIL hstore_wdata: got %h want abcdabcd", wd); end
    checks++; if ({a, we} !== {32'h20, 1'b1}) begin errors++; $display("FAIL hstore_addr_we: addr=%h we=%b want 00000020 1", a, we); end
    checks++; if (sc !== 2) begin errors++; $display("FAIL hstore_stall_cycles: got %0d want 2", sc); end
  endtask

  task automatic test_misaligned();
    int sc; logic ok; logic [31:0] a, wd; logic [3:0] be; logic we;
    set_op(32'h05, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
    @(negedge clk);
    checks++; if ({o_stall, o_mem_req} !== 2'b00) begin errors++;
      $display("FAIL misal_no_req: stall=%b req=%b want 0 0", o_stall, o_mem_req); end
    @(posedge clk); #1;
    set_nop();
    checks++; if ({o_misaligned, o_regWrite, o_read_data, o_mem_req} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin errors++;
      $display("FAIL misal_memwb: mis=%b rw=%b rd=%h req=%b want 1 0 0 0", o_misaligned, o_regWrite, o_read_data, o_mem_req); end
`else
    run_access(1, 32'h11223344, 1'b0, sc, ok, a, wd, be, we);
    checks++; if ({a, ok} !== {32'h04, 1'b1}) begin errors++; $display("FAIL misal_masked_addr: addr=%h req_ok=%b want 00000004 1", a, ok); end
    checks++; if ({o_read_data, o_regWrite, o_misaligned} !== {32'h11223344, 1'b1, 1'b0}) begin errors++;
      $display("FAIL misal_masked_data: rd=%h rw=%b mis=%b want 11223344 1 0", o_read_data, o_regWrite, o_misaligned); end
`endif
  endtask

  task automatic test_halt();
    int sc; logic ok; logic [31:0] a, wd; logic [3:0] be; logic we;
    set_op(32'h77, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    @(posedge clk); #1;
    checks++; if ({o_alu_result, o_write_reg, o_read_data} !== {32'h77, 5'd3, 32'h0}) begin errors++;
      $display("FAIL alu_pass: alu=%h wr=%0d rd=%h want 77 3 0", o_alu_result, o_write_reg, o_read_data); end
    set_op(32'h99, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    i_halt = 1'b1;
    @(negedge clk);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL halt_stall: got %b want 0", o_stall); end
    @(posedge clk); #1;
    checks++; if ({o_alu_result, o_write_reg} !== {32'h77, 5'd3}) begin errors++;
      $display("FAIL halt_hold: alu=%h wr=%0d want 77 3", o_alu_result, o_write_reg); end
    i_halt = 1'b0;
    set_op(32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    run_access(2, 32'h0BAD_F00D, 1'b1, sc, ok, a, wd, be, we);
    checks++; if ({o_read_data, o_alu_result, o_write_reg} !== {32'h0BADF00D, 32'h40, 5'd9}) begin errors++;
      $display("FAIL halt_mid_wait: rd=%h alu=%h wr=%0d want 0badf00d 40 9", o_read_data, o_alu_result, o_write_reg); end
  endtask

  task automatic test_ack_outside_wait();
    set_op(32'h55, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if ({o_mem_req, o_stall} !== 2'b00) begin errors++; $display("FAIL stray_ack_req: req=%b stall=%b want 0 0", o_mem_req, o_stall); end
    @(posedge clk); #1;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    set_nop();
    checks++; if ({o_read_data, o_alu_result} !== {32'h0, 32'h55}) begin errors++;
      $display("FAIL stray_ack_data: rd=%h alu=%h want 0 55", o_read_data, o_alu_result); end
  endtask

  task automatic test_back_to_back();
    int sc; logic ok; logic [31:0] a, wd; logic [3:0] be; logic we;
    set_op(32'h31, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    run_access(0, 32'h0, 1'b0, sc, ok, a, wd, be, we);
    checks++; if ({be, wd, a, we} !== {4'b0010, 32'hA5A5A5A5, 32'h30, 1'b1}) begin errors++;
      $display("FAIL b2b_bstore: be=%b wd=%h addr=%h we=%b want 0010 a5a5a5a5 30 1", be, wd, a, we); end
    set_op(32'h32, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    run_access(0, 32'h8001_0000, 1'b0, sc, ok, a, wd, be, we);
    checks++; if ({sc, ok} !== {32'd1, 1'b1}) begin errors++; $display("FAIL b2b_latency: stalls=%0d req_ok=%b want 1 1", sc, ok); end
    checks++; if ({be, we} !== {4'hF, 1'b0}) begin errors++; $display("FAIL b2b_load_be: be=%b we=%b want 1111 0", be, we); end
    checks++; if (o_read_data !== 32'hFFFF_8001) begin errors++; $display("FAIL b2b_hload: got %h want ffff8001", o_read_data); end
  endtask

  task automatic test_reset_in_wait();
    int sc; logic ok; logic [31:0] a, wd; logic [3:0] be; logic we;
    set_op(32'h88, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (o_mem_req !== 1'b1) begin errors++; $display("FAIL rstw_in_wait: req=%b want 1", o_mem_req); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr} !== '0) begin errors++;
      $display("FAIL rstw_port: req=%b be=%h addr=%h want 0", o_mem_req, o_mem_be, o_mem_addr); end
    checks++; if ({o_read_data, o_alu_result, o_regWrite, o_write_reg} !== '0) begin errors++;
      $display("FAIL rstw_memwb: rd=%h alu=%h want 0", o_read_data, o_alu_result); end
    set_nop();
    @(negedge clk); i_rst_n = 1'b1;
    @(posedge clk); #1;
    set_op(32'h84, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    run_access(1, 32'hCAFEF00D, 1'b0, sc, ok, a, wd, be, we);
    checks++; if ({ok, a, o_read_data, o_write_reg} !== {1'b1, 32'h84, 32'hCAFEF00D, 5'd12}) begin errors++;
      $display("FAIL rstw_restart: ok=%b addr=%h rd=%h wr=%0d want 1 84 cafef00d 12", ok, a, o_read_data, o_write_reg); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_halt();
    test_ack_outside_wait();
    test_back_to_back();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
